// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage and its neighbours.
// Holds address/instruction widths, the halt encoding, the instruction
// field positions used by the decoder, the fetch FSM states and the
// next-PC source selector.
package fetch_pkg;

  localparam int PC_W   = 8;
  localparam int INST_W = 9;

  typedef logic [PC_W-1:0]   pc_t;
  typedef logic [INST_W-1:0] inst_t;

  // Instruction field layout: [8] type, [7:4] opcode, [3:0] register
  localparam int TYPE_BIT = 8;
  localparam int OPC_MSB  = 7;
  localparam int OPC_LSB  = 4;
  localparam int REG_MSB  = 3;
  localparam int REG_LSB  = 0;

  localparam inst_t HALT_INST = 9'b1_1111_0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

  typedef enum logic [1:0] {
    PC_HOLD = 2'd0,
    PC_INC  = 2'd1,
    PC_ABS  = 2'd2,
    PC_REL  = 2'd3
  } pc_sel_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Bus between the fetch stage, the instruction ROM and decode.
// slave  : seen by fetch_unit (control and ROM data in, address and
//          fetch/decode pipeline register out).
// master : seen by the environment driving fetch (decode + ROM).
interface fetch_unit_if;
  import fetch_pkg::*;

  logic  Start;
  pc_t   StartAddr;
  logic  Stall;
  logic  BranchAbs;
  logic  BranchRel;
  pc_t   Target;
  inst_t InstIn;
  pc_t   InstAddress;
  inst_t InstOut;
  pc_t   InstPC;
  logic  InstValid;
  logic  Done;

  modport slave (
    input  Start, StartAddr, Stall, BranchAbs, BranchRel, Target, InstIn,
    output InstAddress, InstOut, InstPC, InstValid, Done
  );

  modport master (
    output Start, StartAddr, Stall, BranchAbs, BranchRel, Target, InstIn,
    input  InstAddress, InstOut, InstPC, InstValid, Done
  );
endinterface

// File: rtl/fetch_unit_next_pc.sv
// Combinational next-PC selector for the fetch stage.
// Ports: pc (current PC), inst_pc (address of the instruction in the
// pipeline register), target (absolute address or signed offset),
// sel (source choice), pc_next (selected next PC).
module next_pc
  import fetch_pkg::*;
(
  input  pc_t     pc,
  input  pc_t     inst_pc,
  input  pc_t     target,
  input  pc_sel_e sel,
  output pc_t     pc_next
);

  always_comb begin
    pc_next = pc;
    case (sel)
      PC_HOLD: pc_next = pc;
      PC_INC:  pc_next = pc + pc_t'(1);
      PC_ABS:  pc_next = target;
      // Same-width add: two's-complement offset, carry dropped, so the
      // sign extension is implicit.
      PC_REL:  pc_next = inst_pc + target;
      default: pc_next = pc;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Program-counter stage feeding the 256x9 instruction ROM.
// Ports: CLK, Reset (synchronous, active-high), bus (fetch_unit_if.slave):
//   Start/StartAddr begin fetch from IDLE or HALTED, Stall freezes the
//   stage, BranchAbs/BranchRel/Target redirect the PC with one squashed
//   slot, InstIn is ROM data for InstAddress, InstOut/InstPC/InstValid
//   form the fetch/decode register, Done is high while HALTED.
module fetch_unit
  import fetch_pkg::*;
(
  input  logic         CLK,
  input  logic         Reset,
  fetch_unit_if.slave  bus
);

  fetch_state_e state_q, state_d;
  pc_t          pc_q, pc_d;
  inst_t        inst_q, inst_d;
  pc_t          inst_pc_q, inst_pc_d;
  logic         valid_q, valid_d;
  logic         done_q, done_d;

  pc_sel_e      pc_sel;
  logic         pc_load;
  pc_t          pc_next;
  logic         branch_valid;

  // A branch only counts when decode is acting on a live instruction.
  assign branch_valid = (bus.BranchAbs | bus.BranchRel) & valid_q;

  next_pc u_next_pc (
    .pc      (pc_q),
    .inst_pc (inst_pc_q),
    .target  (bus.Target),
    .sel     (pc_sel),
    .pc_next (pc_next)
  );

  always_comb begin
    state_d   = state_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    valid_d   = valid_q;
    done_d    = done_q;
    pc_sel    = PC_HOLD;
    pc_load   = 1'b0;

    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (bus.Start) begin
          pc_load = 1'b1;
          state_d = RUN;
        end
      end

      RUN: begin
        if (!bus.Stall) begin
          if (branch_valid) begin
            valid_d = 1'b0;
            pc_sel  = bus.BranchAbs ? PC_ABS : PC_REL;
          end else begin
            inst_d    = bus.InstIn;
            inst_pc_d = pc_q;
            valid_d   = 1'b1;
            if (bus.InstIn == HALT_INST) begin
              state_d = HALTED;
              done_d  = 1'b1;
            end else begin
              pc_sel = PC_INC;
            end
          end
        end
      end

      HALTED: begin
        // Start beats Stall here; otherwise the halt is delivered once.
        if (bus.Start) begin
          pc_load = 1'b1;
          done_d  = 1'b0;
          valid_d = 1'b0;
          state_d = RUN;
        end else if (!bus.Stall) begin
          valid_d = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase

    pc_d = pc_load ? bus.StartAddr : pc_next;
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      inst_q    <= '0;
      inst_pc_q <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
    end
  end

  assign bus.InstAddress = pc_q;
  assign bus.InstOut     = inst_q;
  assign bus.InstPC      = inst_pc_q;
  assign bus.InstValid   = valid_q;
  assign bus.Done        = done_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by
// randomized control traffic, all compared against a behavioural model.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic clk;
  logic reset;
  fetch_unit_if bus ();

  inst_t rom [256];

  int check_count;
  int fail_count;

  // Reference model state (integers, stepped once per clock)
  int m_state;   // 0 idle, 1 running, 2 halted
  int m_pc;
  int m_out;
  int m_ipc;
  int m_valid;
  int m_done;

  fetch_unit u_dut (
    .CLK   (clk),
    .Reset (reset),
    .bus   (bus)
  );

  assign bus.InstIn = rom[bus.InstAddress];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts one comparison and reports it if it disagrees.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Model of one clock edge, written from the behavioural rules.
  task automatic modelStep(input bit rst, input bit start, input int sa,
                           input bit stall, input bit babs, input bit brel,
                           input int tgt);
    int fetched;
    if (rst) begin
      m_state = 0; m_pc = 0; m_out = 0; m_ipc = 0; m_valid = 0; m_done = 0;
    end else if (m_state == 0) begin
      m_valid = 0;
      if (start) begin
        m_pc = sa;
        m_state = 1;
      end
    end else if (m_state == 1) begin
      if (stall) begin
        // everything frozen
      end else if ((babs || brel) && m_valid == 1) begin
        m_valid = 0;
        if (babs) m_pc = tgt;
        else      m_pc = (m_ipc + tgt) % 256;
      end else begin
        fetched = int'(rom[m_pc]);
        m_out   = fetched;
        m_ipc   = m_pc;
        m_valid = 1;
        if (fetched == int'(HALT_INST)) begin
          m_state = 2;
          m_done  = 1;
        end else begin
          m_pc = (m_pc + 1) % 256;
        end
      end
    end else begin
      if (start) begin
        m_pc = sa; m_done = 0; m_valid = 0; m_state = 1;
      end else if (!stall) begin
        m_valid = 0;
      end
    end
  endtask

  // Drives one cycle of inputs, steps the model and compares after the edge.
  task automatic applyStimulus(input bit rst, input bit start, input int sa,
                               input bit stall, input bit babs, input bit brel,
                               input int tgt);
    @(negedge clk);
    reset         = rst;
    bus.Start     = start;
    bus.StartAddr = pc_t'(sa);
    bus.Stall     = stall;
    bus.BranchAbs = babs;
    bus.BranchRel = brel;
    bus.Target    = pc_t'(tgt);
    modelStep(rst, start, sa, stall, babs, brel, tgt);
    @(posedge clk);
    #1;
    checkOutput("InstAddress", 32'(bus.InstAddress), 32'(m_pc));
    checkOutput("InstOut",     32'(bus.InstOut),     32'(m_out));
    checkOutput("InstPC",      32'(bus.InstPC),      32'(m_ipc));
    checkOutput("InstValid",   32'(bus.InstValid),   32'(m_valid));
    checkOutput("Done",        32'(bus.Done),        32'(m_done));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic restart(input int sa);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, sa, 0, 0, 0, 0);
  endtask

  initial begin
    check_count = 0;
    fail_count  = 0;
    reset = 1'b1;
    bus.Start = 0; bus.StartAddr = '0; bus.Stall = 0;
    bus.BranchAbs = 0; bus.BranchRel = 0; bus.Target = '0;
    m_state = 0; m_pc = 0; m_out = 0; m_ipc = 0; m_valid = 0; m_done = 0;

    for (int i = 0; i < 256; i++) begin
      rom[i] = inst_t'($urandom);
      if (rom[i] == HALT_INST) rom[i] = '0;
    end
    rom[8'h22] = HALT_INST;
    rom[8'h90] = HALT_INST;

    // Reset values
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("reset_valid", 32'(bus.InstValid), 32'd0);

    // Start at 0x10, straight-line fetch
    applyStimulus(0, 1, 8'h10, 0, 0, 0, 0);
    checkOutput("start_addr", 32'(bus.InstAddress), 32'h10);
    idle(3);
    checkOutput("lag_pc", 32'(bus.InstPC), 32'h12);

    // Wrap from 0xFF to 0x00
    restart(8'hFE);
    idle(5);

    // Absolute branch while InstPC=0x05
    restart(8'h04);
    idle(2);
    applyStimulus(0, 0, 0, 0, 1, 0, 8'h40);
    checkOutput("abs_squash", 32'(bus.InstValid), 32'd0);
    idle(1);
    checkOutput("abs_landed", 32'(bus.InstPC), 32'h40);

    // Relative branch -4 from InstPC=0x02, held off by 3 stalled cycles
    restart(8'h01);
    idle(2);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 0, 1, 8'hFC);
    applyStimulus(0, 0, 0, 0, 0, 1, 8'hFC);
    checkOutput("rel_target", 32'(bus.InstAddress), 32'hFE);
    idle(2);

    // Halt at 0x22: delivered once, then restart from 0
    restart(8'h20);
    idle(3);
    checkOutput("halt_done", 32'(bus.Done), 32'd1);
    applyStimulus(0, 0, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("halt_once", 32'(bus.InstValid), 32'd0);
    idle(2);
    applyStimulus(0, 1, 0, 1, 0, 0, 0);
    checkOutput("restart_done", 32'(bus.Done), 32'd0);
    idle(2);

    // Reset mid-run at PC=0x33
    restart(8'h30);
    idle(3);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    idle(3);
    checkOutput("post_reset_pc", 32'(bus.InstAddress), 32'd0);

    // Randomized control traffic
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 99) == 0),
                    ($urandom_range(0, 9) == 0),
                    int'($urandom_range(0, 255)),
                    ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 7) == 0),
                    int'($urandom_range(0, 255)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule
